uart_tx_mmio_queue: RTL and testbench

//  Memory-mapped transmit queue between the CPU data-store path and the uart_tx serializer.

---
 rtl/uart_tx_mmio_queue_pkg.sv | 17 +
 rtl/uart_tx_mmio_queue_if.sv | 21 ++
 rtl/uart_tx_mmio_queue_fifo.sv | 43 ++++
 rtl/uart_tx_mmio_queue.sv | 87 ++++++++
 tb/tb_uart_tx_mmio_queue.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_queue_pkg.sv
// uart_mmio_pkg: register offsets, STATUS bit layout and drain FSM encoding for uart_tx_mmio_queue
package uart_mmio_pkg;
    localparam logic [2:0] TXDATA_OFF = 3'd0;
    localparam logic [2:0] STATUS_OFF = 3'd4;
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_ACTIVE  = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_COUNT   = 8;
    localparam int ST_OVF_CNT = 16;
    typedef logic [1:0] drain_state_t;
    localparam drain_state_t IDLE      = 2'd0;
    localparam drain_state_t START     = 2'd1;
    localparam drain_state_t WAIT_BUSY = 2'd2;
    localparam drain_state_t WAIT_IDLE = 2'd3;
    localparam logic [1:0] WAIT_TIMEOUT = 2'd2;
endpackage

// File: rtl/uart_tx_mmio_queue_if.sv
// uart_tx_mmio_queue_if: CPU data-store bus plus the uart_tx start/busy handshake
interface uart_tx_mmio_queue_if;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_sel;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        irq_empty;
    modport master (
        output bus_addr, bus_we, bus_re, bus_wdata, tx_busy,
        input  bus_rdata, bus_sel, tx_start, tx_data, irq_empty
    );
    modport slave (
        input  bus_addr, bus_we, bus_re, bus_wdata, tx_busy,
        output bus_rdata, bus_sel, tx_start, tx_data, irq_empty
    );
endinterface

// File: rtl/uart_tx_mmio_queue_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with first-word-fall-through read at rd_ptr
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
endmodule

// File: rtl/uart_tx_mmio_queue.sv
// uart_tx_mmio_queue: MMIO transmit queue feeding uart_tx; UART_TX_OVF_CNT_EN adds a dropped-byte counter
module uart_tx_mmio_queue
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_tx_mmio_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             hit, wr_tx, wr_st, ovf_set, ovf_clr, pop;
    logic             full, empty, active, ovf, tx_start, unused_bits;
    logic [CNT_W-1:0] count;
    logic [7:0]       fifo_q, tx_data;
    logic [15:0]      ovf_cnt;
    logic [1:0]       wait_cnt;
    logic [31:0]      status;
    drain_state_t     state;

    assign hit         = bus.bus_addr[31:3] == BASE_ADDR[31:3];
    assign wr_tx       = bus.bus_we && hit && bus.bus_addr[2:0] == TXDATA_OFF;
    assign wr_st       = bus.bus_we && hit && bus.bus_addr[2:0] == STATUS_OFF;
    assign ovf_set     = wr_tx && full;
    assign ovf_clr     = wr_st && bus.bus_wdata[ST_OVF];
    assign pop         = state == IDLE && !empty && !bus.tx_busy;
    assign active      = state != IDLE || bus.tx_busy;
    assign status      = {ovf_cnt, 8'(count), 4'b0, ovf, active, empty, full};
    assign unused_bits = ^{bus.bus_re, bus.bus_wdata[31:8]};

    assign bus.bus_sel   = hit;
    assign bus.bus_rdata = (hit && bus.bus_addr[2:0] == STATUS_OFF) ? status : '0;
    assign bus.tx_start  = tx_start;
    assign bus.tx_data   = tx_data;
    assign bus.irq_empty = empty && !active;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_tx),
        .pop   (pop),
        .wdata (bus.bus_wdata[7:0]),
        .rdata (fifo_q),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf <= 1'b0;
        else ovf <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;

`ifdef UART_TX_OVF_CNT_EN
    // Saturating dropped-byte counter; a drop coinciding with a clear is still counted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_cnt <= '0;
        else ovf_cnt <= ovf_clr ? 16'(ovf_set) : (ovf_set && ovf_cnt != 16'hFFFF) ? ovf_cnt + 16'd1 : ovf_cnt;
`else
    assign ovf_cnt = '0;
`endif

    // Drain FSM: one byte per start/busy handshake, tolerating a uart that never raises busy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            wait_cnt <= '0;
        end else begin
            tx_start <= pop;
            if (pop) tx_data <= fifo_q;
            case (state)
                IDLE:      if (pop) state <= START;
                START: begin
                    state    <= WAIT_BUSY;
                    wait_cnt <= '0;
                end
                WAIT_BUSY: if (bus.tx_busy || wait_cnt == WAIT_TIMEOUT - 2'd1) state <= WAIT_IDLE;
                           else wait_cnt <= wait_cnt + 2'd1;
                WAIT_IDLE: if (!bus.tx_busy) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_tx_mmio_queue.sv
// tb_uart_tx_mmio_queue: scoreboard bench with a queue-level reference model and a uart_tx busy model
module tb_uart_tx_mmio_queue;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

    logic clk = 0;
    logic rst_n;
    uart_tx_mmio_queue_if bus();

    uart_tx_mmio_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0] exp_q[$];
    int occ = 0, exp_ovfc = 0, mode = 0, fixed_len = 0, left = 0;
    int cyc = 0, nstarts = 0, last_cyc = 0, prev_cyc = 0;
    logic exp_ovf = 0, prev_start = 0;
    logic [7:0] cur = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor plus uart_tx busy model, in one process for deterministic ordering
    initial begin
        bus.tx_busy = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_start = 0;
                left = 0;
                bus.tx_busy = 0;
            end else begin
                if (bus.tx_start) begin
                    nstarts++;
                    prev_cyc = last_cyc;
                    last_cyc = cyc;
                    chk("tx_start single cycle", prev_start, 0);
                    chk("tx_start expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("tx_data order", bus.tx_data, exp_q.pop_front());
                        occ--;
                    end
                    cur = bus.tx_data;
                end else if (mode == 0 && bus.tx_busy) begin
                    chk("tx_data stable while busy", bus.tx_data, cur);
                end
                prev_start = bus.tx_start;
                if (mode == 0) begin
                    if (bus.tx_start) left = fixed_len != 0 ? fixed_len : $urandom_range(1, 4);
                    else if (left > 0) left--;
                    bus.tx_busy = left > 0;
                end else begin
                    left = 0;
                    bus.tx_busy = mode == 1;
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.bus_addr = a;
        bus.bus_wdata = d;
        bus.bus_we = 1;
        @(negedge clk);
        #1;
        if (a == BASE) begin
            if (occ < DEPTH) begin
                exp_q.push_back(d[7:0]);
                occ++;
            end else begin
                exp_ovf = 1;
                if (exp_ovfc < 65535) exp_ovfc++;
            end
        end else if (a == BASE + 4 && d[3]) begin
            exp_ovf = 0;
            exp_ovfc = 0;
        end
        @(posedge clk);
        #1;
        bus.bus_we = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic s);
        bus.bus_addr = a;
        bus.bus_re = 1;
        @(negedge clk);
        #1;
        v = bus.bus_rdata;
        s = bus.bus_sel;
        @(posedge clk);
        #1;
        bus.bus_re = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string nm);
        logic [31:0] v;
        logic s;
        rd(BASE + 4, v, s);
        chk({nm, " count"}, 32'(v[15:8]), 32'(occ));
        chk({nm, " full"}, v[0], occ == DEPTH);
        chk({nm, " empty"}, v[1], occ == 0);
        chk({nm, " ovf"}, v[3], exp_ovf);
`ifdef UART_TX_OVF_CNT_EN
        chk({nm, " ovf_cnt"}, 32'(v[31:16]), 32'(exp_ovfc));
`else
        chk({nm, " ovf_cnt"}, 32'(v[31:16]), 0);
`endif
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int n = 0;
        while (!(bus.irq_empty && exp_q.size() == 0) && n < lim) begin
            tick(1);
            n++;
        end
        chk({nm, " drained within budget"}, bus.irq_empty && exp_q.size() == 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic s;
        int n0;
        rst_n = 0;
        bus.bus_addr = BASE + 4;
        bus.bus_we = 0;
        bus.bus_re = 0;
        bus.bus_wdata = 0;
        #12;
        chk("reset tx_start", bus.tx_start, 0);
        chk("reset tx_data", bus.tx_data, 0);
        chk("reset irq_empty", bus.irq_empty, 1);
        chk("reset status", bus.bus_rdata, 32'h2);
        chk("reset bus_sel", bus.bus_sel, 1);
        #10 rst_n = 1;
        tick(1);

        store(BASE, 32'h41);
        @(negedge clk);
        chk("t1 tx_start after 1st edge", bus.tx_start, 0);
        @(negedge clk);
        chk("t1 tx_start after 2nd edge", bus.tx_start, 1);
        chk("t1 tx_data", bus.tx_data, 8'h41);
        @(negedge clk);
        chk("t1 tx_start one cycle", bus.tx_start, 0);
        tick(1);
        rd(BASE + 4, v, s);
        chk("t1 active", v[2], 1);
        wait_idle("t1", 60);
        rd(BASE + 4, v, s);
        chk("t1 active after drain", v[2], 0);
        chk("t1 irq_empty", bus.irq_empty, 1);

        mode = 1;
        tick(2);
        for (int i = 0; i < 17; i++) store(BASE, 32'h60 + i);
        chk_status("t2");
        rd(BASE + 4, v, s);
        chk("t2 count 16", 32'(v[15:8]), 16);
        chk("t2 full", v[0], 1);
        chk("t2 ovf", v[3], 1);
`ifdef UART_TX_OVF_CNT_EN
        chk("t2 ovf_cnt", 32'(v[31:16]), 1);
`endif
        store(BASE + 4, 32'h8);
        rd(BASE + 4, v, s);
        chk("t6 ovf cleared", v[3], 0);
        chk("t6 ovf_cnt cleared", 32'(v[31:16]), 0);
        chk_status("t6");
        mode = 0;
        wait_idle("t2", 400);

        mode = 1;
        tick(2);
        for (int i = 0; i < 5; i++) store(BASE, 32'h80 + i);
        mode = 0;
        store(BASE, 32'h99);
        rd(BASE + 4, v, s);
        chk("t3 count stays 5", 32'(v[15:8]), 5);
        chk_status("t3");
        wait_idle("t3", 200);
        for (int i = 0; i < 32; i++) begin
            store(BASE, 32'(i));
            tick($urandom_range(3, 6));
        end
        wait_idle("t3 wrap", 600);
        chk_status("t3 wrap");

        mode = 2;
        tick(1);
        store(BASE, 32'hA5);
        store(BASE, 32'h5A);
        wait_idle("t4", 60);
        chk("t4 timeout gap", 32'(last_cyc - prev_cyc), 5);
        mode = 0;

        fixed_len = 30;
        for (int i = 0; i < 4; i++) store(BASE, 32'hC0 + i);
        tick(3);
        #2;
        rst_n = 0;
        bus.bus_addr = BASE + 4;
        #1;
        chk("t5 tx_start", bus.tx_start, 0);
        chk("t5 tx_data", bus.tx_data, 0);
        chk("t5 irq_empty", bus.irq_empty, 1);
        chk("t5 status", bus.bus_rdata, 32'h2);
        exp_q.delete();
        occ = 0;
        exp_ovf = 0;
        exp_ovfc = 0;
        fixed_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        n0 = nstarts;
        tick(12);
        chk("t5 no tx_start after reset", 32'(nstarts - n0), 0);

        rd(32'h0000_2000, v, s);
        chk("t6 outside sel", s, 0);
        chk("t6 outside rdata", v, 0);
        rd(BASE + 8, v, s);
        chk("t6 next word sel", s, 0);
        rd(BASE, v, s);
        chk("t6 txdata sel", s, 1);
        chk("t6 txdata reads 0", v, 0);
        store(BASE + 2, 32'h77);
        store(32'h0000_2000, 32'h78);
        tick(4);
        chk_status("t6 unmapped");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) store(BASE + 4, 32'h8);
            store(BASE, $urandom);
            if ($urandom_range(0, 5) == 0) chk_status("rand");
            tick($urandom_range(0, 4));
        end
        wait_idle("rand", 1500);
        chk_status("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
